// File: rtl/prog_iram_pkg.sv
// Shared processor package: opcode constants, instruction-RAM loader states and helpers.
package prog_iram_pkg;

  localparam logic [7:0] OP_HALT = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_NOP  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_JMP  = 8'h05;
  localparam logic [7:0] OP_BRZ  = 8'h06;
  localparam logic [7:0] OP_ST   = 8'h07;

  // Out-of-range fetches hand the core a harmless instruction.
  localparam logic [7:0] NOP_CODE_DEFAULT = OP_NOP;

  typedef enum logic [1:0] {
    IRAM_IDLE = 2'd0,
    IRAM_LOAD = 2'd1,
    IRAM_DONE = 2'd2
  } iram_state_e;

  // Evaluated in 32 bits so base+len never wraps for any realistic ADDR_W.
  function automatic logic load_fits(input int unsigned base,
                                     input int unsigned len,
                                     input int unsigned depth);
    return (len != 0) && ((base + len) <= depth);
  endfunction

endpackage

// File: rtl/prog_iram_mem.sv
// Parametrised synchronous RAM: one write port, one registered read port that holds when idle.
module iram_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // The array itself is never reset so a reset keeps any loaded program.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_iram.sv
// Program instruction RAM: single-cycle fetch port plus a streaming loader that fills a window.
module prog_iram
  import prog_iram_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_CODE = DATA_W'(NOP_CODE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              addr_err,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  iram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              valid_q, addr_err_q, nop_sel_q;
  logic              zero_done_q, err_q;

  logic              in_idle, in_load;
  logic              fetch_act, fetch_in_range;
  logic              start_req, start_zero, start_fits, start_bad;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;

  assign in_idle = (state_q == IRAM_IDLE);
  assign in_load = (state_q == IRAM_LOAD);

  assign fetch_act      = in_idle && fetch_en;
  assign fetch_in_range = (32'(addr) < 32'(DEPTH));

  assign start_req  = in_idle && load_start;
  assign start_zero = (load_len == '0);
  assign start_fits = load_fits(32'(load_base), 32'(load_len), 32'(DEPTH));
  assign start_bad  = start_req && !start_zero && !start_fits;

  assign mem_we = in_load && ld_valid;
  assign mem_re = fetch_act && fetch_in_range;

  iram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (ptr_q),
    .wdata_i (ld_data),
    .re_i    (mem_re),
    .raddr_i (addr),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    case (state_q)
      IRAM_IDLE: begin
        if (start_req && start_fits) begin
          state_d     = IRAM_LOAD;
          ptr_d       = load_base;
          remaining_d = load_len;
        end
      end
      IRAM_LOAD: begin
        if (ld_valid) begin
          ptr_d       = ptr_q + ADDR_W'(1);
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          if (remaining_q == (ADDR_W+1)'(1)) begin
            state_d = IRAM_DONE;
          end
        end
      end
      IRAM_DONE: state_d = IRAM_IDLE;
      default:   state_d = IRAM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IRAM_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
    end
  end

  // nop_sel_q only moves on a real fetch, so dout holds whatever was last fetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      nop_sel_q   <= 1'b0;
      zero_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      valid_q     <= fetch_act;
      addr_err_q  <= fetch_act && !fetch_in_range;
      zero_done_q <= start_req && start_zero;
      err_q       <= start_bad;
      if (fetch_act) begin
        nop_sel_q <= !fetch_in_range;
      end
    end
  end

  assign dout       = nop_sel_q ? NOP_CODE : mem_rdata;
  assign dout_valid = valid_q;
  assign addr_err   = addr_err_q;
  assign ld_ready   = in_load;
  assign load_busy  = in_load;
  assign load_done  = (state_q == IRAM_DONE) || zero_done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_prog_iram.sv
// Self-checking bench for prog_iram against an array model of the program memory.
module tb_prog_iram;

  localparam int DEPTH = 200;
  localparam logic [7:0] NOP = 8'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch_en = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] dout;
  logic       dout_valid, addr_err;
  logic       load_start = 1'b0;
  logic [7:0] load_base = '0;
  logic [8:0] load_len = '0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_ready, load_busy, load_done, load_err;

  int total = 0;
  int bad = 0;
  logic [7:0] expMem [DEPTH];
  logic [7:0] expDout = '0;

  always #5 clk = ~clk;

  prog_iram #(
    .DATA_W (8),
    .ADDR_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .addr       (addr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .addr_err   (addr_err),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_dout"}, 32'(dout), 0);
    checkOutput({tag, "_valid"}, 32'(dout_valid), 0);
    checkOutput({tag, "_aerr"}, 32'(addr_err), 0);
    checkOutput({tag, "_ready"}, 32'(ld_ready), 0);
    checkOutput({tag, "_busy"}, 32'(load_busy), 0);
    checkOutput({tag, "_done"}, 32'(load_done), 0);
    checkOutput({tag, "_lerr"}, 32'(load_err), 0);
  endtask

  task automatic doFetch(input int a);
    fetch_en = 1'b1;
    addr = 8'(a);
    tick();
    fetch_en = 1'b0;
    expDout = (a < DEPTH) ? expMem[a] : NOP;
    checkOutput("fetchValid", 32'(dout_valid), 1);
    checkOutput("fetchAddrErr", 32'(addr_err), (a >= DEPTH) ? 1 : 0);
    checkOutput("fetchData", 32'(dout), 32'(expDout));
    tick();
    checkOutput("fetchValidDrop", 32'(dout_valid), 0);
    checkOutput("fetchAddrErrDrop", 32'(addr_err), 0);
    checkOutput("fetchHold", 32'(dout), 32'(expDout));
  endtask

  task automatic randomFetches(input int n);
    for (int i = 0; i < n; i++) begin
      logic fe;
      int a;
      fe = 1'($urandom_range(1));
      a = $urandom_range(255);
      fetch_en = fe;
      addr = 8'(a);
      ld_valid = 1'($urandom_range(1));
      ld_data = 8'($urandom);
      tick();
      if (fe) expDout = (a < DEPTH) ? expMem[a] : NOP;
      checkOutput("rndValid", 32'(dout_valid), 32'(fe));
      checkOutput("rndAddrErr", 32'(addr_err), (fe && a >= DEPTH) ? 1 : 0);
      checkOutput("rndData", 32'(dout), 32'(expDout));
      checkOutput("rndIdleReady", 32'(ld_ready), 0);
    end
    fetch_en = 1'b0;
    ld_valid = 1'b0;
  endtask

  // dataBase < 0 means random words; patLen 0 means random ld_valid gaps.
  task automatic doLoad(input int base, input int len, input logic [15:0] pat,
                        input int patLen, input int dataBase, input bit holdFetch);
    int accepted = 0;
    int cycles = 0;
    bit fits;
    logic [7:0] frozen;
    fits = (len > 0) && (base + len <= DEPTH);
    load_start = 1'b1;
    load_base = 8'(base);
    load_len = 9'(len);
    tick();
    load_start = 1'b0;
    if (len == 0) begin
      checkOutput("zeroDone", 32'(load_done), 1);
      checkOutput("zeroBusy", 32'(load_busy), 0);
      checkOutput("zeroErr", 32'(load_err), 0);
      tick();
      checkOutput("zeroDoneOnce", 32'(load_done), 0);
      checkOutput("zeroBusyAfter", 32'(load_busy), 0);
      return;
    end
    if (!fits) begin
      checkOutput("errPulse", 32'(load_err), 1);
      checkOutput("errBusy", 32'(load_busy), 0);
      checkOutput("errDone", 32'(load_done), 0);
      tick();
      checkOutput("errOnce", 32'(load_err), 0);
      checkOutput("errBusyAfter", 32'(load_busy), 0);
      return;
    end
    frozen = expDout;
    if (holdFetch) begin
      fetch_en = 1'b1;
      addr = 8'(base);
    end
    while (accepted < len && cycles < 500) begin
      checkOutput("ldBusy", 32'(load_busy), 1);
      checkOutput("ldReady", 32'(ld_ready), 1);
      checkOutput("ldDoneEarly", 32'(load_done), 0);
      if (holdFetch) begin
        checkOutput("holdValid", 32'(dout_valid), 0);
        checkOutput("holdDout", 32'(dout), 32'(frozen));
      end
      ld_valid = (patLen > 0) ? pat[cycles % patLen] : ($urandom_range(3) != 0);
      ld_data = (dataBase >= 0) ? 8'(dataBase + accepted) : 8'($urandom);
      load_start = 1'($urandom_range(1));
      load_base = '0;
      load_len = 9'd1;
      @(posedge clk);
      if (ld_valid) begin
        expMem[base + accepted] = ld_data;
        accepted++;
      end
      #1;
      cycles++;
    end
    if (cycles >= 500) checkOutput("loadTimeout", 32'(accepted), 32'(len));
    checkOutput("donePulse", 32'(load_done), 1);
    checkOutput("doneBusy", 32'(load_busy), 0);
    checkOutput("doneReady", 32'(ld_ready), 0);
    checkOutput("doneValid", 32'(dout_valid), 0);
    ld_valid = 1'b1;
    ld_data = 8'($urandom);
    load_start = 1'b1;
    tick();
    ld_valid = 1'b0;
    load_start = 1'b0;
    checkOutput("doneOnce", 32'(load_done), 0);
    checkOutput("idleBusy", 32'(load_busy), 0);
    checkOutput("idleValid", 32'(dout_valid), 0);
    if (holdFetch) begin
      checkOutput("holdDoutDone", 32'(dout), 32'(frozen));
      tick();
      fetch_en = 1'b0;
      expDout = expMem[base];
      checkOutput("postLoadValid", 32'(dout_valid), 1);
      checkOutput("postLoadData", 32'(dout), 32'(expDout));
    end
  endtask

  initial begin
    #3;
    checkResetOutputs("por");
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkResetOutputs("idle");

    // Fill the whole memory (exact-fit boundary) so every model word is known.
    doLoad(0, DEPTH, 16'h0, 0, -1, 1'b0);
    randomFetches(150);

    doLoad(0, 3, 16'hFFFF, 1, 7, 1'b0);
    for (int a = 0; a < 3; a++) begin
      doFetch(a);
      checkOutput("seqWord", 32'(dout), 32'(7 + a));
    end

    doLoad(195, 10, 16'h0, 0, -1, 1'b0);
    doFetch(195);
    doLoad(190, 10, 16'h0, 0, -1, 1'b0);
    doFetch(199);
    doLoad(250, 0, 16'h0, 0, -1, 1'b0);

    doFetch(210);
    doFetch(200);
    doFetch(255);

    doLoad(100, 4, 16'b1011001, 7, -1, 1'b0);
    for (int a = 99; a < 105; a++) doFetch(a);

    doFetch(5);
    doLoad(150, 6, 16'h0, 0, -1, 1'b1);

    load_start = 1'b1;
    load_base = 8'd20;
    load_len = 9'd5;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data = 8'($urandom);
      @(posedge clk);
      expMem[20 + i] = ld_data;
      #1;
    end
    ld_valid = 1'b0;
    checkOutput("preRstBusy", 32'(load_busy), 1);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("midRst");
    expDout = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("rstNoDone", 32'(load_done), 0);
    checkOutput("rstNoBusy", 32'(load_busy), 0);
    for (int a = 20; a < 25; a++) doFetch(a);

    for (int i = 0; i < 6; i++) begin
      doLoad($urandom_range(255), $urandom_range(40), 16'h0, 0, -1, 1'($urandom_range(1)));
    end
    randomFetches(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/prog_iram.md
PROG_IRAM -- requirements
Module: prog_iram

Interface
REQ-001 Parameter DATA_W, default 8, instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 256, number of words stored; DEPTH SHALL be at most 2**ADDR_W.
REQ-004 Parameter NOP_CODE, default 8'd2, word returned for an out-of-range fetch.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 fetch_en  in  1  fetch request for addr.
REQ-008 addr  in  ADDR_W  fetch address.
REQ-009 dout  out  DATA_W  fetched instruction word.
REQ-010 dout_valid  out  1  dout updated this cycle.
REQ-011 addr_err  out  1  one-cycle pulse: last fetch was out of range.
REQ-012 load_start  in  1  one-cycle pulse that begins a program load.
REQ-013 load_base  in  ADDR_W  first word address of the load.
REQ-014 load_len  in  ADDR_W+1  number of words to load.
REQ-015 ld_valid  in  1  ld_data is valid.
REQ-016 ld_data  in  DATA_W  program word to store.
REQ-017 ld_ready  out  1  block accepts ld_data this cycle.
REQ-018 load_busy  out  1  load in progress.
REQ-019 load_done  out  1  one-cycle pulse: load completed.
REQ-020 load_err  out  1  one-cycle pulse: load request rejected.

Function
REQ-021 Storage SHALL be a DEPTH x DATA_W array with one synchronous write port and one synchronous read port.
REQ-022 FSM states: IDLE, LOAD, DONE.
REQ-023 In IDLE, fetch_en=1 with addr<DEPTH: dout=mem[addr] and dout_valid=1 on the next edge (latency 1).
REQ-024 In IDLE, fetch_en=1 with addr>=DEPTH: dout=NOP_CODE, dout_valid=1 and addr_err=1 on the next edge.
REQ-025 fetch_en=0, or any state other than IDLE: dout_valid=0, addr_err=0, and dout holds its previous value.
REQ-026 IDLE->LOAD on load_start when 0<load_len and load_base+load_len<=DEPTH, evaluated at full width with no wrap; ptr<=load_base, remaining<=load_len.
REQ-027 load_start with load_len=0: load_done pulses on the next cycle and the FSM stays in IDLE.
REQ-028 load_start with load_base+load_len>DEPTH: load_err pulses on the next cycle, the FSM stays in IDLE, and memory is not written.
REQ-029 In LOAD: ld_ready=1 and load_busy=1; each cycle with ld_valid&&ld_ready writes mem[ptr]<=ld_data, increments ptr and decrements remaining.
REQ-030 Accepting the word that takes remaining to 0 moves the FSM to DONE; DONE asserts load_done for one cycle, then returns to IDLE.
REQ-031 load_start while in LOAD or DONE is ignored.
REQ-032 ld_valid while in IDLE or DONE is ignored: ld_ready=0 and no write occurs.
REQ-033 A fetch issued in the cycle DONE->IDLE returns the newly loaded data.

Reset
REQ-034 On rst: FSM=IDLE, dout=0, dout_valid=0, addr_err=0, ld_ready=0, load_busy=0, load_done=0, load_err=0, ptr=0, remaining=0.
REQ-035 Memory contents are not cleared by reset; a reset during LOAD aborts the load, keeps words already written, and does not pulse load_done.

Structure
REQ-036 The FSM state encoding and the default NOP_CODE constant SHALL live in the shared processor package alongside the opcode constants.
REQ-037 One sub-module, iram_mem (a parametrised synchronous RAM), SHALL hold the storage; prog_iram holds the FSM, counters and fetch logic.

Verification
REQ-038 Load base=0, len=3 with data 7,8,9 and ld_valid continuous -> ld_ready high 3 cycles, load_done pulse; then fetches of addr 0,1,2 -> 7,8,9 with dout_valid, each 1 cycle after its request.
REQ-039 Load base=250, len=10 (DEPTH=256) -> load_err pulse, load_busy stays 0, and a fetch of addr 250 returns the prior contents.
REQ-040 DEPTH=200, fetch addr=210 -> dout=2, dout_valid=1, addr_err=1 for one cycle.
REQ-041 Load len=4 with ld_valid gapped (1,0,0,1,1,0,1) -> exactly 4 writes at base..base+3, and load_done only after the 4th accepted word.
REQ-042 Reset asserted after 2 of 5 words -> all outputs at reset values immediately (asynchronously); the 2 written words read back, and the remaining 3 locations are unchanged.
REQ-043 fetch_en held high during a load -> dout_valid=0 throughout LOAD and DONE, and dout frozen.
